// File: rtl/nmea_num_field_parser_pkg.sv
// Shared ASCII constants and FSM state type for the NMEA numeric field parser.
package nmea_num_field_parser_pkg;

  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_UA    = 8'h41;
  localparam logic [7:0] CH_UF    = 8'h46;
  localparam logic [7:0] CH_LA    = 8'h61;
  localparam logic [7:0] CH_LF_HEX = 8'h66;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

endpackage

// File: rtl/nmea_num_field_parser_if.sv
// Character-in / result-out handshake bundle for the field parser.
interface nmea_num_field_parser_if #(
  parameter int B  = 8,
  parameter int L  = 2,
  parameter int DW = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [B-1:0]     in_char;
  logic             radix_dec;
  logic             out_valid;
  logic             out_ready;
  logic [L*B-1:0]   out_num;
  logic [DW-1:0]    out_digits;
  logic             out_bad;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_char, radix_dec, out_ready,
    output in_ready, out_valid, out_num, out_digits, out_bad, out_ovf
  );

  modport master (
    output in_valid, in_char, radix_dec, out_ready,
    input  in_ready, out_valid, out_num, out_digits, out_bad, out_ovf
  );
endinterface

// File: rtl/nmea_num_field_parser_hex_digit_decode.sv
// Classifies one ASCII char as digit (with its value) or field terminator.
module hex_digit_decode
  import nmea_num_field_parser_pkg::*;
#(
  parameter int B = 8
) (
  input  logic [B-1:0] ch,
  input  logic         radix_dec,
  output logic         is_digit,
  output logic         is_term,
  output logic [3:0]   value
);

  always_comb begin
    is_digit = 1'b0;
    value    = 4'd0;
    if (ch >= B'(CH_0) && ch <= B'(CH_9)) begin
      is_digit = 1'b1;
      value    = 4'(ch - B'(CH_0));
    end else if (!radix_dec && ch >= B'(CH_UA) && ch <= B'(CH_UF)) begin
      is_digit = 1'b1;
      value    = 4'(ch - B'(CH_UA) + B'(10));
    end else if (!radix_dec && ch >= B'(CH_LA) && ch <= B'(CH_LF_HEX)) begin
      is_digit = 1'b1;
      value    = 4'(ch - B'(CH_LA) + B'(10));
    end
  end

  assign is_term = (ch == B'(CH_COMMA)) || (ch == B'(CH_STAR)) ||
                   (ch == B'(CH_CR))    || (ch == B'(CH_LF));

endmodule

// File: rtl/nmea_num_field_parser.sv
// Streaming ASCII field to binary converter: accumulates digits in hex or decimal
// and presents one result per terminated field with bad-char and overflow flags.
module nmea_num_field_parser
  import nmea_num_field_parser_pkg::*;
#(
  parameter int B  = 8,
  parameter int L  = 2,
  parameter int DW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nmea_num_field_parser_if.slave bus
);

  localparam int W  = L*B;
  localparam int WX = W + 4;

  state_t          state;
  logic [W-1:0]    acc;
  logic [DW-1:0]   digits;
  logic            bad;
  logic            ovf;
  logic            radix_q;

  logic            beat;
  logic            eff_radix;
  logic            is_digit;
  logic            is_term;
  logic [3:0]      value;
  logic [WX-1:0]   wide;
  logic [WX-1:0]   prod;
  logic [WX-1:0]   next_val;
  logic            sat;

  // The first char of a field decodes with the live radix; later chars use the latched one.
  assign eff_radix = (state == IDLE) ? bus.radix_dec : radix_q;
  assign beat      = bus.in_valid && bus.in_ready;

  hex_digit_decode #(.B(B)) u_decode (
    .ch        (bus.in_char),
    .radix_dec (eff_radix),
    .is_digit  (is_digit),
    .is_term   (is_term),
    .value     (value)
  );

  // acc*10 = acc*8 + acc*2; the four guard bits catch any overflow of one step.
  always_comb begin
    wide     = {4'b0000, acc};
    prod     = radix_q ? ((wide << 3) + (wide << 1)) : (wide << 4);
    next_val = prod + WX'(value);
    sat      = ovf || (|next_val[WX-1:W]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      digits  <= '0;
      bad     <= 1'b0;
      ovf     <= 1'b0;
      radix_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            radix_q <= bus.radix_dec;
            if (is_digit) begin
              acc    <= W'(value);
              digits <= DW'(1);
              state  <= ACC;
            end else if (is_term) begin
              state  <= DONE;
            end else begin
              bad    <= 1'b1;
              state  <= ACC;
            end
          end
        end
        ACC: begin
          if (beat) begin
            if (is_digit) begin
              if (sat) begin
                ovf <= 1'b1;
                acc <= '1;
              end else begin
                acc <= next_val[W-1:0];
              end
              if (digits != '1) digits <= digits + DW'(1);
            end else if (is_term) begin
              state <= DONE;
            end else begin
              bad <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state  <= IDLE;
            acc    <= '0;
            digits <= '0;
            bad    <= 1'b0;
            ovf    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state != DONE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_num    = acc;
  assign bus.out_digits = digits;
  assign bus.out_bad    = bad;
  assign bus.out_ovf    = ovf;

endmodule
